// File: rtl/irq_mask_controller_if.sv
// irq_mask_controller_if: request, mask, acknowledge and pending-output bundle of the PIC mask stage
interface irq_mask_controller_if #(
    parameter int CHANNELS = 8
) ();
    localparam int ID_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0] ir_in;
    logic                ltim;
    logic                imr_wr;
    logic [CHANNELS-1:0] imr_data;
    logic                ack;
    logic [CHANNELS-1:0] ack_vec;
    logic [CHANNELS-1:0] irr_q;
    logic [CHANNELS-1:0] imr_q;
    logic [CHANNELS-1:0] pending;
    logic                int_req;
    logic [ID_W-1:0]     irq_id;

    modport master (
        output ir_in, ltim, imr_wr, imr_data, ack, ack_vec,
        input  irr_q, imr_q, pending, int_req, irq_id
    );

    modport slave (
        input  ir_in, ltim, imr_wr, imr_data, ack, ack_vec,
        output irr_q, imr_q, pending, int_req, irq_id
    );
endinterface

// File: rtl/irq_mask_controller.sv
// irq_mask_controller: synchronises interrupt lines, latches IRR, holds IMR and picks the lowest pending channel
module irq_mask_controller #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] MASK_RESET  = '0
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    irq_mask_controller_if.slave  bus
);
    localparam int ID_W = $clog2(CHANNELS);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] ir_s, ir_prev_q, rise, clr;
    logic [CHANNELS-1:0] irr_q, irr_d, imr_q, imr_d, pending;
    logic [ID_W-1:0]     irq_id;

    assign ir_s = sync_q[SYNC_STAGES-1];
    assign rise = ir_s & ~ir_prev_q;
    assign clr  = bus.ack ? bus.ack_vec : '0;

    // Synchroniser chain plus a one-cycle delayed copy used for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            ir_prev_q <= '0;
        end else begin
            sync_q[0] <= bus.ir_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            ir_prev_q <= ir_s;
        end
    end

    // Next IRR follows the line in level mode; in edge mode a new rise beats a same-cycle clear
    always_comb begin
        irr_d = bus.ltim ? (ir_s & ~clr) : ((irr_q & ~clr) | rise);
        imr_d = bus.imr_wr ? bus.imr_data : imr_q;
    end

    // IRR and IMR registers; masked channels still latch so unmasking releases them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irr_q <= '0;
            imr_q <= MASK_RESET;
        end else begin
            irr_q <= irr_d;
            imr_q <= imr_d;
        end
    end

    assign pending = irr_q & ~imr_q;

    // Fixed-priority encoder: scanning downward leaves the lowest set bit as the winner
    always_comb begin
        irq_id = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (pending[i]) irq_id = ID_W'(i);
    end

    assign bus.irr_q   = irr_q;
    assign bus.imr_q   = imr_q;
    assign bus.pending = pending;
    assign bus.int_req = |pending;
    assign bus.irq_id  = irq_id;
endmodule
